// File: rtl/sdram_init.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init
// Purpose  : SDR SDRAM power-up initialisation sequencer. Holds NOP for the
//            power-up interval, then issues PrechargeAll, REFRESH_COUNT
//            AutoRefresh commands and a ModeRegisterSet, then raises
//            initDone (sticky until reset). All outputs are registered.
// Options  : define SDRAM_INIT_DEBUG_EN to add the initState port and a
//            $display trace of every issued command.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_init #(
  parameter int          POWERUP_CYCLES = 10000,
  parameter int          TRP_CYCLES     = 2,
  parameter int          TRFC_CYCLES    = 7,
  parameter int          TMRD_CYCLES    = 2,
  parameter int          REFRESH_COUNT  = 2,
  parameter logic [12:0] MODE_VALUE     = 13'h0037
) (
  input  logic        clock,
  input  logic        reset,
  output logic [6:0]  command,
  output logic [12:0] addr,
  output logic [1:0]  bank,
`ifdef SDRAM_INIT_DEBUG_EN
  output logic [2:0]  initState,
`endif
  output logic        initDone
);

  // Command encodings {CKE,CS_N,RAS_N,CAS_N,WE_N,LDQM,UDQM}
  localparam logic [6:0] CMD_NOP  = 7'b1100000;
  localparam logic [6:0] CMD_PREA = 7'b1001000;
  localparam logic [6:0] CMD_AREF = 7'b1000100;
  localparam logic [6:0] CMD_MRS  = 7'b1000000;

  // Counter must hold the largest interval it is compared against
  localparam int MAX_A = (POWERUP_CYCLES > TRP_CYCLES) ? POWERUP_CYCLES : TRP_CYCLES;
  localparam int MAX_B = (TRFC_CYCLES > TMRD_CYCLES) ? TRFC_CYCLES : TMRD_CYCLES;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);
  localparam int RW    = (REFRESH_COUNT < 1) ? 1 : $clog2(REFRESH_COUNT + 1);

  localparam logic [CW-1:0] P_CNT = CW'(POWERUP_CYCLES);
  localparam logic [CW-1:0] R_CNT = CW'(TRP_CYCLES);
  localparam logic [CW-1:0] F_CNT = CW'(TRFC_CYCLES);
  localparam logic [CW-1:0] M_CNT = CW'(TMRD_CYCLES);
  localparam logic [RW-1:0] N_CNT = RW'(REFRESH_COUNT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [2:0] {
    POWERUP   = 3'd0,
    PRECHARGE = 3'd1,
    WAIT_TRP  = 3'd2,
    REFRESH   = 3'd3,
    WAIT_TRFC = 3'd4,
    MODE      = 3'd5,
    WAIT_TMRD = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [6:0]    command_q, command_d;
  logic [12:0]   addr_q, addr_d;
  logic [1:0]    bank_q, bank_d;
  logic          done_q, done_d;

  // State, counters and registered bus outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= POWERUP;
      cnt_q     <= '0;
      ref_q     <= '0;
      command_q <= CMD_NOP;
      addr_q    <= '0;
      bank_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_q     <= ref_d;
      command_q <= command_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      done_q    <= done_d;
    end
  end

  // Next state and next outputs. cnt_q counts cycles since the last command
  // (1 in the command cycle itself), so a command state with a 1-cycle
  // timing jumps straight to the next command and skips its wait state.
  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + ONE;
    ref_d     = ref_q;
    command_d = CMD_NOP;
    addr_d    = '0;
    bank_d    = '0;
    done_d    = 1'b0;

    case (state_q)
      POWERUP: begin
        if (cnt_q == P_CNT) begin
          state_d = PRECHARGE;
          cnt_d   = ONE;
        end
      end
      PRECHARGE, WAIT_TRP: begin
        if (cnt_q == R_CNT) begin
          state_d = REFRESH;
          cnt_d   = ONE;
          ref_d   = ref_q + RW'(1);
        end else begin
          state_d = WAIT_TRP;
        end
      end
      REFRESH, WAIT_TRFC: begin
        if (cnt_q == F_CNT) begin
          cnt_d = ONE;
          if (ref_q < N_CNT) begin
            state_d = REFRESH;
            ref_d   = ref_q + RW'(1);
          end else begin
            state_d = MODE;
          end
        end else begin
          state_d = WAIT_TRFC;
        end
      end
      MODE, WAIT_TMRD: begin
        if (cnt_q == M_CNT) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          state_d = WAIT_TMRD;
        end
      end
      default: begin
        state_d = DONE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      PRECHARGE: begin
        command_d = CMD_PREA;
        addr_d    = 13'h0400;
      end
      REFRESH:   command_d = CMD_AREF;
      MODE: begin
        command_d = CMD_MRS;
        addr_d    = MODE_VALUE;
      end
      DONE:      done_d = 1'b1;
      default:   command_d = CMD_NOP;
    endcase
  end

  assign command  = command_q;
  assign addr     = addr_q;
  assign bank     = bank_q;
  assign initDone = done_q;

`ifdef SDRAM_INIT_DEBUG_EN
  assign initState = state_q;

  // Trace each command as it is registered onto the bus
  always_ff @(posedge clock) begin
    if (!reset) begin
      case (state_d)
        PRECHARGE: $display("At time %t: Command => PrechargeAll", $time);
        REFRESH:   $display("At time %t: Command => AutoRefresh", $time);
        MODE:      $display("At time %t: Command => ModeRegisterSet", $time);
        default:   ;
      endcase
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_init.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_init
// Purpose  : Self-checking bench for sdram_init. Two instances: scaled
//            defaults (P=20 R=2 F=7 M=2 N=2) and a short-timing build
//            (P=5 R=1 F=3 M=1 N=4). Expected schedules come from event tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_init;

  localparam logic [6:0] NOP  = 7'b1100000;
  localparam logic [6:0] PREA = 7'b1001000;
  localparam logic [6:0] AREF = 7'b1000100;
  localparam logic [6:0] MRS  = 7'b1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  cmd_a, cmd_b;
  logic [12:0] addr_a, addr_b;
  logic [1:0]  bank_a, bank_b;
  logic        done_a, done_b;
`ifdef SDRAM_INIT_DEBUG_EN
  logic [2:0]  st_a, st_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_init #(
    .POWERUP_CYCLES(20), .TRP_CYCLES(2), .TRFC_CYCLES(7),
    .TMRD_CYCLES(2), .REFRESH_COUNT(2), .MODE_VALUE(13'h0037)
  ) dut_a (
    .clock(clk), .reset(rst), .command(cmd_a), .addr(addr_a), .bank(bank_a),
`ifdef SDRAM_INIT_DEBUG_EN
    .initState(st_a),
`endif
    .initDone(done_a)
  );

  sdram_init #(
    .POWERUP_CYCLES(5), .TRP_CYCLES(1), .TRFC_CYCLES(3),
    .TMRD_CYCLES(1), .REFRESH_COUNT(4), .MODE_VALUE(13'h0037)
  ) dut_b (
    .clock(clk), .reset(rst), .command(cmd_b), .addr(addr_b), .bank(bank_b),
`ifdef SDRAM_INIT_DEBUG_EN
    .initState(st_b),
`endif
    .initDone(done_b)
  );

  typedef struct {
    int          cyc;
    logic [6:0]  cmd;
    logic [12:0] addr;
  } ev_t;

  ev_t tab_a[4];
  ev_t tab_b[6];
  localparam int DONE_A = 38;
  localparam int DONE_B = 19;

  function automatic logic [22:0] exp_a(input int c);
    logic [22:0] r;
    r = {NOP, 13'h0, 2'b00, (c >= DONE_A)};
    for (int i = 0; i < 4; i++)
      if (tab_a[i].cyc == c) r = {tab_a[i].cmd, tab_a[i].addr, 2'b00, 1'b0};
    return r;
  endfunction

  function automatic logic [22:0] exp_b(input int c);
    logic [22:0] r;
    r = {NOP, 13'h0, 2'b00, (c >= DONE_B)};
    for (int i = 0; i < 6; i++)
      if (tab_b[i].cyc == c) r = {tab_b[i].cmd, tab_b[i].addr, 2'b00, 1'b0};
    return r;
  endfunction

  task automatic cmp(input string name, input int c, input logic [22:0] got, input logic [22:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got cmd=%b addr=%h bank=%0d done=%b, want cmd=%b addr=%h bank=%0d done=%b",
               name, c, got[22:16], got[15:3], got[2:1], got[0],
               want[22:16], want[15:3], want[2:1], want[0]);
    end
  endtask

  task automatic cmp_state(input string name, input int c, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got state=%0d want state=%0d", name, c, got, want);
    end
  endtask

  // Check both instances for cycles s..e after a reset release
  task automatic run(input int s, input int e);
    for (int c = s; c <= e; c++) begin
      @(negedge clk);
      cmp("sched_a", c, {cmd_a, addr_a, bank_a, done_a}, exp_a(c));
      cmp("sched_b", c, {cmd_b, addr_b, bank_b, done_b}, exp_b(c));
`ifdef SDRAM_INIT_DEBUG_EN
      if (c == 0)       cmp_state("state_a", c, st_a, 3'd0);
      if (c == 20)      cmp_state("state_a", c, st_a, 3'd1);
      if (c == 21)      cmp_state("state_a", c, st_a, 3'd2);
      if (c == 22)      cmp_state("state_a", c, st_a, 3'd3);
      if (c == 23)      cmp_state("state_a", c, st_a, 3'd4);
      if (c == 36)      cmp_state("state_a", c, st_a, 3'd5);
      if (c == 37)      cmp_state("state_a", c, st_a, 3'd6);
      if (c >= DONE_A)  cmp_state("state_a", c, st_a, 3'd7);
`endif
    end
  endtask

  task automatic check_reset(input int c);
    @(negedge clk);
    cmp("reset_a", c, {cmd_a, addr_a, bank_a, done_a}, {NOP, 13'h0, 2'b00, 1'b0});
    cmp("reset_b", c, {cmd_b, addr_b, bank_b, done_b}, {NOP, 13'h0, 2'b00, 1'b0});
  endtask

  initial begin
    tab_a[0] = '{20, PREA, 13'h0400};
    tab_a[1] = '{22, AREF, 13'h0000};
    tab_a[2] = '{29, AREF, 13'h0000};
    tab_a[3] = '{36, MRS,  13'h0037};
    tab_b[0] = '{5,  PREA, 13'h0400};
    tab_b[1] = '{6,  AREF, 13'h0000};
    tab_b[2] = '{9,  AREF, 13'h0000};
    tab_b[3] = '{12, AREF, 13'h0000};
    tab_b[4] = '{15, AREF, 13'h0000};
    tab_b[5] = '{18, MRS,  13'h0037};

    // Held reset: outputs stay at reset values
    rst = 1'b1;
    for (int i = 0; i < 10; i++) check_reset(-1);

    // Release, then a 1-cycle reset pulse at cycle 25 (inside tRFC wait)
    rst = 1'b0;
    run(0, 24);
    rst = 1'b1;
    check_reset(25);
    rst = 1'b0;

    // Full sequence from the new release, then a long idle stretch in DONE
    run(0, 1040);

    // Reset out of DONE clears initDone on the next edge
    rst = 1'b1;
    check_reset(1041);
    rst = 1'b0;
    run(0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
